// File: rtl/debug_mode_scheduler_if.sv
// Command/handshake bundle between the debugger front end and the mode scheduler.
// The slave side is the scheduler; the master side drives received bytes and done pulses.
interface debug_mode_scheduler_if #(
    parameter int CNT_W = 32
);
    logic [7:0]       i_rx_data;
    logic             is_rx_done;
    logic             is_load_done;
    logic             is_fast_done;
    logic             is_step_done;
    logic             is_stop_pipe;
    logic             os_load_start;
    logic             os_fast_start;
    logic             os_step_start;
    logic             os_cmd_err;
    logic             os_timeout;
    logic [2:0]       o_state;
    logic             o_busy;
    logic             o_loaded;
    logic [CNT_W-1:0] o_step_count;

    modport slave (
        input  i_rx_data, is_rx_done, is_load_done, is_fast_done, is_step_done, is_stop_pipe,
        output os_load_start, os_fast_start, os_step_start, os_cmd_err, os_timeout,
        output o_state, o_busy, o_loaded, o_step_count
    );

    modport master (
        output i_rx_data, is_rx_done, is_load_done, is_fast_done, is_step_done, is_stop_pipe,
        input  os_load_start, os_fast_start, os_step_start, os_cmd_err, os_timeout,
        input  o_state, o_busy, o_loaded, o_step_count
    );
endinterface

// File: rtl/debug_mode_scheduler.sv
// Debugger top-level sequencer: decodes UART command bytes and runs exactly one debug mode
// (load, continuous run, single step) at a time, with an optional per-mode watchdog.
module debug_mode_scheduler #(
    parameter logic [7:0] CMD_LOAD = 8'h4C,
    parameter logic [7:0] CMD_FAST = 8'h43,
    parameter logic [7:0] CMD_STEP = 8'h53,
    parameter logic [7:0] CMD_EXIT = 8'h45,
    parameter int         CNT_W    = 32,
    parameter int         TIMEOUT  = 0
) (
    input logic                   clk,
    input logic                   rst,
    debug_mode_scheduler_if.slave dbg
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FAST      = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STEP_RUN  = 3'd4
    } state_e;

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             loaded_q, loaded_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             load_start_q, load_start_d;
    logic             fast_start_q, fast_start_d;
    logic             step_start_q, step_start_d;
    logic             cmd_err_q, cmd_err_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             wd_expire;

    // Expiry fires on the last allowed cycle so the IDLE return lands exactly TIMEOUT cycles in.
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        halt_d       = halt_q;
        count_d      = count_q;
        load_start_d = 1'b0;
        fast_start_d = 1'b0;
        step_start_d = 1'b0;
        cmd_err_d    = 1'b0;
        timeout_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dbg.is_rx_done) begin
                    if (dbg.i_rx_data == CMD_LOAD) begin
                        state_d      = ST_LOAD;
                        load_start_d = 1'b1;
                    end else if (dbg.i_rx_data == CMD_FAST && loaded_q) begin
                        state_d      = ST_FAST;
                        fast_start_d = 1'b1;
                    end else if (dbg.i_rx_data == CMD_STEP && loaded_q) begin
                        state_d = ST_STEP_WAIT;
                        count_d = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Bytes arriving here are program data for the loader, not commands.
                if (dbg.is_load_done) begin
                    state_d  = ST_IDLE;
                    loaded_d = 1'b1;
                end else if (wd_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    loaded_d  = 1'b0;
                end
            end
            ST_FAST: begin
                cmd_err_d = dbg.is_rx_done;
                if (dbg.is_fast_done) begin
                    state_d  = ST_IDLE;
                    loaded_d = 1'b0;
                end else if (wd_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    loaded_d  = 1'b0;
                end
            end
            ST_STEP_WAIT: begin
                if (dbg.is_rx_done) begin
                    if (dbg.i_rx_data == CMD_STEP) begin
                        state_d      = ST_STEP_RUN;
                        step_start_d = 1'b1;
                        count_d      = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (dbg.i_rx_data == CMD_EXIT) begin
                        state_d = ST_IDLE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_STEP_RUN: begin
                cmd_err_d = dbg.is_rx_done;
                if (dbg.is_step_done) begin
                    if (halt_q || dbg.is_stop_pipe) begin
                        state_d  = ST_IDLE;
                        loaded_d = 1'b0;
                    end else begin
                        state_d = ST_STEP_WAIT;
                    end
                end else if (wd_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    loaded_d  = 1'b0;
                end else if (dbg.is_stop_pipe) begin
                    halt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // HALT only matters for the step in flight; forget it once the step run ends.
        if (state_d != ST_STEP_RUN) begin
            halt_d = 1'b0;
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_FAST) || (state_d == ST_STEP_RUN);

        if ((state_d != state_q) || !busy_q) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            loaded_q     <= 1'b0;
            halt_q       <= 1'b0;
            count_q      <= '0;
            wd_q         <= '0;
            load_start_q <= 1'b0;
            fast_start_q <= 1'b0;
            step_start_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            halt_q       <= halt_d;
            count_q      <= count_d;
            wd_q         <= wd_d;
            load_start_q <= load_start_d;
            fast_start_q <= fast_start_d;
            step_start_q <= step_start_d;
            cmd_err_q    <= cmd_err_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign dbg.os_load_start = load_start_q;
    assign dbg.os_fast_start = fast_start_q;
    assign dbg.os_step_start = step_start_q;
    assign dbg.os_cmd_err    = cmd_err_q;
    assign dbg.os_timeout    = timeout_q;
    assign dbg.o_state       = state_q;
    assign dbg.o_busy        = busy_q;
    assign dbg.o_loaded      = loaded_q;
    assign dbg.o_step_count  = count_q;
endmodule

// File: tb/tb_debug_mode_scheduler.sv
// Bench for debug_mode_scheduler: directed scenarios with literal expectations, then random
// traffic compared every cycle against a mode/event level reference model.
module tb_debug_mode_scheduler;
    localparam int         TMO = 16;
    localparam logic [7:0] B_L = 8'h4C;
    localparam logic [7:0] B_C = 8'h43;
    localparam logic [7:0] B_S = 8'h53;
    localparam logic [7:0] B_E = 8'h45;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_mode_scheduler_if #(.CNT_W(32)) bus ();

    debug_mode_scheduler #(.CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .dbg (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: mode number 0..4, cycles spent in the mode, expected pulses.
    int          m_mode, m_age;
    bit          m_loaded, m_halt;
    logic [31:0] m_cnt;
    bit          m_ls, m_fs, m_ss, m_err, m_to;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_loaded = 0; m_halt = 0; m_cnt = 0;
        m_ls = 0; m_fs = 0; m_ss = 0; m_err = 0; m_to = 0;
    endtask

    function automatic bit is_busy_mode(input int md);
        return (md == 1) || (md == 2) || (md == 4);
    endfunction

    // Applies one clock edge worth of inputs to the model.
    task automatic model_step(input logic [7:0] d, input bit rx, input bit ld, input bit fd,
                              input bit sd, input bit sp);
        int  nm;
        bit  dog;
        nm = m_mode;
        m_ls = 0; m_fs = 0; m_ss = 0; m_err = 0; m_to = 0;
        dog = is_busy_mode(m_mode) && (m_age + 1 == TMO);
        if (m_mode == 0 && rx) begin
            if (d == B_L)                  begin nm = 1; m_ls = 1; end
            else if (d == B_C && m_loaded) begin nm = 2; m_fs = 1; end
            else if (d == B_S && m_loaded) begin nm = 3; m_cnt = 0; end
            else m_err = 1;
        end else if (m_mode == 3 && rx) begin
            if (d == B_S)      begin nm = 4; m_ss = 1; m_cnt = m_cnt + 1; end
            else if (d == B_E) nm = 0;
            else m_err = 1;
        end else if ((m_mode == 2 || m_mode == 4) && rx) begin
            m_err = 1;
        end
        if (m_mode == 1 && ld)      begin nm = 0; m_loaded = 1; end
        else if (m_mode == 2 && fd) begin nm = 0; m_loaded = 0; end
        else if (m_mode == 4 && sd) begin
            if (m_halt || sp) begin nm = 0; m_loaded = 0; end
            else nm = 3;
        end else if (dog) begin
            nm = 0; m_to = 1; m_loaded = 0;
        end else if (m_mode == 4 && sp) begin
            m_halt = 1;
        end
        if (nm != 4) m_halt = 0;
        m_age  = (nm == m_mode) ? m_age + 1 : 0;
        m_mode = nm;
    endtask

    // One clock: drive inputs shortly after the falling edge, update model, return just after rise.
    task automatic cyc(input logic [7:0] d, input bit rx, input bit ld, input bit fd,
                       input bit sd, input bit sp);
        @(negedge clk);
        #2;
        bus.i_rx_data    = d;
        bus.is_rx_done   = rx;
        bus.is_load_done = ld;
        bus.is_fast_done = fd;
        bus.is_step_done = sd;
        bus.is_stop_pipe = sp;
        model_step(d, rx, ld, fd, sd, sp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(); cyc(8'h00, 0, 0, 0, 0, 0); endtask
    task automatic rxb(input logic [7:0] d); cyc(d, 1, 0, 0, 0, 0); endtask

    // Compare process: outputs settle after the rising edge and are checked on the falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("state",      bus.o_state,       m_mode);
            chk("busy",       bus.o_busy,        is_busy_mode(m_mode));
            chk("loaded",     bus.o_loaded,      m_loaded);
            chk("step_count", bus.o_step_count,  m_cnt);
            chk("load_start", bus.os_load_start, m_ls);
            chk("fast_start", bus.os_fast_start, m_fs);
            chk("step_start", bus.os_step_start, m_ss);
            chk("cmd_err",    bus.os_cmd_err,    m_err);
            chk("timeout",    bus.os_timeout,    m_to);
            chk("one_start",  64'($countones({bus.os_load_start, bus.os_fast_start,
                                              bus.os_step_start}) <= 1), 1);
        end
    end

    initial begin
        bus.i_rx_data = 0; bus.is_rx_done = 0; bus.is_load_done = 0;
        bus.is_fast_done = 0; bus.is_step_done = 0; bus.is_stop_pipe = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",  bus.o_state, 0);
        chk("rst_loaded", bus.o_loaded, 0);
        chk("rst_count",  bus.o_step_count, 0);
        @(negedge clk);
        #2;
        rst = 0;
        chk_en = 1;

        // FAST without a program is rejected.
        rxb(B_C);
        chk("t1_err", bus.os_cmd_err, 1);
        chk("t1_state", bus.o_state, 0);
        chk("t1_fast", bus.os_fast_start, 0);
        idle();
        chk("t1_err_len", bus.os_cmd_err, 0);

        // Load with data bytes, then a fast run to halt.
        rxb(B_L);
        chk("t2_lstart", bus.os_load_start, 1);
        chk("t2_state_load", bus.o_state, 1);
        for (int i = 0; i < 5; i++) rxb(8'($urandom_range(0, 255)));
        chk("t2_data_noerr", bus.os_cmd_err, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t2_loaded", bus.o_loaded, 1);
        chk("t2_state_idle", bus.o_state, 0);
        rxb(B_C);
        chk("t2_fstart", bus.os_fast_start, 1);
        chk("t2_busy", bus.o_busy, 1);
        rxb(B_S);
        chk("t6_err_fast", bus.os_cmd_err, 1);
        chk("t6_state_fast", bus.o_state, 2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t2_fast_idle", bus.o_state, 0);
        chk("t2_fast_unload", bus.o_loaded, 0);

        // Step mode: entry, two steps, exit.
        rxb(B_L); cyc(0, 0, 1, 0, 0, 0);
        rxb(B_S);
        chk("t3_enter", bus.o_state, 3);
        chk("t3_no_step", bus.os_step_start, 0);
        rxb(B_S);
        chk("t3_sstart", bus.os_step_start, 1);
        chk("t3_run", bus.o_state, 4);
        cyc(0, 0, 0, 0, 1, 0);
        rxb(B_S);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t3_count", bus.o_step_count, 2);
        chk("t3_wait", bus.o_state, 3);
        rxb(B_E);
        chk("t3_exit", bus.o_state, 0);
        chk("t3_keep_loaded", bus.o_loaded, 1);

        // HALT coinciding with the step report ends step mode.
        rxb(B_S); rxb(B_S);
        cyc(0, 0, 0, 0, 1, 1);
        chk("t4_state", bus.o_state, 0);
        chk("t4_loaded", bus.o_loaded, 0);

        // Watchdog expiry, then a done pulse on the expiry cycle.
        rxb(B_L);
        repeat (TMO - 1) idle();
        chk("t5_still_load", bus.o_state, 1);
        idle();
        chk("t5_timeout", bus.os_timeout, 1);
        chk("t5_to_idle", bus.o_state, 0);
        rxb(B_L);
        repeat (TMO - 1) idle();
        cyc(0, 0, 1, 0, 0, 0);
        chk("t5_no_timeout", bus.os_timeout, 0);
        chk("t5_loaded", bus.o_loaded, 1);

        // Asynchronous reset in the middle of a fast run.
        rxb(B_C);
        chk("t6_fast", bus.o_state, 2);
        #2;
        rst = 1;
        #1;
        chk("t6_rst_state", bus.o_state, 0);
        chk("t6_rst_busy", bus.o_busy, 0);
        chk("t6_rst_loaded", bus.o_loaded, 0);
        chk("t6_rst_pulses", {bus.os_load_start, bus.os_fast_start, bus.os_step_start,
                              bus.os_cmd_err, bus.os_timeout}, 0);
        model_reset();
        bus.i_rx_data = 0; bus.is_rx_done = 0; bus.is_fast_done = 0;
        @(negedge clk);
        #2;
        rst = 0;

        // Random traffic, biased toward valid command bytes.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
                0: d = B_L;
                1: d = B_C;
                2: d = B_S;
                3: d = B_E;
                default: d = 8'($urandom_range(0, 255));
            endcase
            cyc(d, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 7) == 0);
        end
        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
